// File: rtl/throw_trajectory_pkg.sv
// Shared screen geometry, timing defaults and types for the projectile flight.
package variable_pkg;

  localparam int DEF_SCREEN_W    = 1024;
  localparam int DEF_GROUND_Y    = 700;
  localparam int DEF_X_CAT_START = 100;
  localparam int DEF_X_DOG_START = 900;
  localparam int DEF_Y_START     = 600;
  localparam int DEF_VY_BASE     = 8;
  localparam int DEF_STEP_CYCLES = 1000000;
  localparam int DEF_TGT_X_CAT   = 80;
  localparam int DEF_TGT_X_DOG   = 880;
  localparam int DEF_TGT_Y       = 560;
  localparam int DEF_TGT_W       = 40;
  localparam int DEF_TGT_H       = 60;

  typedef enum logic [1:0] {IDLE, FLY, DONE, RELEASE} state_t;

  typedef logic signed [12:0] coord_t;

endpackage

// File: rtl/throw_trajectory_step_tick.sv
// Physics step timer: counts 0..CYCLES-1 while enabled and flags the last count.
module step_tick #(
  parameter int CYCLES = 4
) (
  input  logic clk60MHz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/throw_trajectory.sv
// Projectile flight controller for the throw handshake; optional crosswind
// input is enabled with THROW_TRAJECTORY_WIND_EN.
module throw_trajectory
  import variable_pkg::*;
#(
  parameter int X_CAT_START = DEF_X_CAT_START,
  parameter int X_DOG_START = DEF_X_DOG_START,
  parameter int Y_START     = DEF_Y_START,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int VY_BASE     = DEF_VY_BASE,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int TGT_X_CAT   = DEF_TGT_X_CAT,
  parameter int TGT_X_DOG   = DEF_TGT_X_DOG,
  parameter int TGT_Y       = DEF_TGT_Y,
  parameter int TGT_W       = DEF_TGT_W,
  parameter int TGT_H       = DEF_TGT_H
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        throw_flag,
  input  logic [3:0]  power,
  input  logic        current_player,
`ifdef THROW_TRAJECTORY_WIND_EN
  input  logic [3:0]  wind,
`endif
  output logic        end_throw,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        visible,
  output logic        hit,
  output logic        busy
);

  // state   | meaning
  // IDLE    | waiting for throw_flag
  // FLY     | projectile moving, one physics step per tick
  // DONE    | flight over, end_throw pulses
  // RELEASE | waiting for the meter to drop throw_flag

  localparam coord_t X_CAT_C     = coord_t'(X_CAT_START);
  localparam coord_t X_DOG_C     = coord_t'(X_DOG_START);
  localparam coord_t Y_START_C   = coord_t'(Y_START);
  localparam coord_t GROUND_C    = coord_t'(GROUND_Y);
  localparam coord_t X_MAX_C     = coord_t'(SCREEN_W - 1);
  localparam coord_t TGT_X_CAT_C = coord_t'(TGT_X_CAT);
  localparam coord_t TGT_X_DOG_C = coord_t'(TGT_X_DOG);
  localparam coord_t TGT_W_M1    = coord_t'(TGT_W - 1);
  localparam coord_t TGT_Y_C     = coord_t'(TGT_Y);
  localparam coord_t TGT_Y_MAX_C = coord_t'(TGT_Y + TGT_H - 1);
  localparam logic signed [7:0] VY_MIN = -8'sd64;

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [4:0]        vx_q, vx_d;
  logic signed [7:0] vy_q, vy_d;
  coord_t            x_q, x_d, y_q, y_d;
  logic              hit_q, hit_d, visible_q, visible_d;
  logic              end_throw_q, end_throw_d, busy_q, busy_d;
  logic [11:0]       xpos_q, xpos_d, ypos_q, ypos_d;

  logic   launch, tick, in_box, off_field;
  coord_t vx_ext, vy_ext, wind_ext, x_move, x_step, y_step, tgt_x;

`ifdef THROW_TRAJECTORY_WIND_EN
  logic [3:0] wind_q, wind_d;

  always_comb begin
    wind_d = launch ? wind : wind_q;
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) wind_q <= '0;
    else     wind_q <= wind_d;
  end

  assign wind_ext = {{9{wind_q[3]}}, wind_q};
`else
  assign wind_ext = '0;
`endif

  step_tick #(.CYCLES(STEP_CYCLES)) u_step_tick (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .en       (state_q == FLY),
    .clr      (launch),
    .tick     (tick)
  );

  assign vx_ext    = {8'b0, vx_q};
  assign vy_ext    = {{5{vy_q[7]}}, vy_q};
  assign x_move    = dir_q ? (x_q - vx_ext) : (x_q + vx_ext);
  assign x_step    = x_move + wind_ext;
  assign y_step    = y_q - vy_ext;
  // A cat throw (dir=0) aims at the dog box and vice versa.
  assign tgt_x     = dir_q ? TGT_X_CAT_C : TGT_X_DOG_C;
  assign in_box    = (x_step >= tgt_x) && (x_step <= tgt_x + TGT_W_M1) &&
                     (y_step >= TGT_Y_C) && (y_step <= TGT_Y_MAX_C);
  assign off_field = (y_step >= GROUND_C) || (x_step < 13'sd0) || (x_step > X_MAX_C);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    x_d         = x_q;
    y_d         = y_q;
    hit_d       = hit_q;
    visible_d   = visible_q;
    end_throw_d = 1'b0;
    busy_d      = busy_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    launch      = 1'b0;
    case (state_q)
      IDLE: begin
        if (throw_flag) begin
          launch    = 1'b1;
          dir_d     = current_player;
          vx_d      = 5'(power) + 5'd1;
          vy_d      = 8'(VY_BASE + int'(power));
          x_d       = current_player ? X_DOG_C : X_CAT_C;
          y_d       = Y_START_C;
          hit_d     = 1'b0;
          visible_d = 1'b1;
          busy_d    = 1'b1;
          xpos_d    = x_d[11:0];
          ypos_d    = y_d[11:0];
          state_d   = FLY;
        end
      end
      FLY: begin
        if (tick) begin
          x_d    = x_step;
          y_d    = y_step;
          vy_d   = (vy_q == VY_MIN) ? VY_MIN : vy_q - 8'sd1;
          xpos_d = x_step[11:0];
          ypos_d = y_step[11:0];
          if (in_box || off_field) begin
            hit_d       = in_box;
            visible_d   = 1'b0;
            end_throw_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: state_d = RELEASE;
      RELEASE: begin
        if (!throw_flag) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      vx_q        <= '0;
      vy_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hit_q       <= 1'b0;
      visible_q   <= 1'b0;
      end_throw_q <= 1'b0;
      busy_q      <= 1'b0;
      xpos_q      <= '0;
      ypos_q      <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hit_q       <= hit_d;
      visible_q   <= visible_d;
      end_throw_q <= end_throw_d;
      busy_q      <= busy_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
    end
  end

  assign end_throw = end_throw_q;
  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign visible   = visible_q;
  assign hit       = hit_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_throw_trajectory.sv
// Scoreboard bench: two instances (default geometry and a small-target variant)
// share stimulus; a flight model predicts each landing.
module tb_throw_trajectory;

  localparam int STEP = 4;

  typedef struct {
    int ticks;
    int x;
    int y;
    int hit;
  } exp_t;

  logic clk60MHz = 1'b0;
  always #5 clk60MHz = ~clk60MHz;

  logic       rst = 1'b1;
  logic       throw_flag = 1'b0;
  logic [3:0] power = '0;
  logic       current_player = 1'b0;
`ifdef THROW_TRAJECTORY_WIND_EN
  logic [3:0] wind = '0;
`endif

  logic        a_end, a_vis, a_hit, a_busy, b_end, b_vis, b_hit, b_busy;
  logic [11:0] a_x, a_y, b_x, b_y;

  throw_trajectory #(.STEP_CYCLES(STEP)) dut_a (
    .clk60MHz(clk60MHz), .rst(rst), .throw_flag(throw_flag), .power(power),
    .current_player(current_player),
`ifdef THROW_TRAJECTORY_WIND_EN
    .wind(wind),
`endif
    .end_throw(a_end), .xpos(a_x), .ypos(a_y), .visible(a_vis), .hit(a_hit), .busy(a_busy)
  );

  throw_trajectory #(.STEP_CYCLES(STEP), .X_DOG_START(40), .TGT_X_DOG(110),
                     .TGT_Y(590), .TGT_W(20), .TGT_H(20)) dut_b (
    .clk60MHz(clk60MHz), .rst(rst), .throw_flag(throw_flag), .power(power),
    .current_player(current_player),
`ifdef THROW_TRAJECTORY_WIND_EN
    .wind(wind),
`endif
    .end_throw(b_end), .xpos(b_x), .ypos(b_y), .visible(b_vis), .hit(b_hit), .busy(b_busy)
  );

  int tests = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Flight from the rules: move, apply gravity, then test target box and field limits.
  function automatic exp_t model(input int pw, input int pl, input int wd, input int dog_x,
                                 input int dog_box_x, input int box_y, input int bw, input int bh);
    exp_t e;
    int x, y, vy, bx, dx;
    x  = pl ? dog_x : 100;
    y  = 600;
    vy = 8 + pw;
    bx = pl ? 80 : dog_box_x;
    dx = pl ? -(pw + 1) : (pw + 1);
    e.ticks = -1;
    e.hit   = 0;
    for (int n = 1; n <= 4000; n++) begin
      x = x + dx + wd;
      y = y - vy;
      if (vy > -64) vy = vy - 1;
      if (x >= bx && x <= bx + bw - 1 && y >= box_y && y <= box_y + bh - 1) begin
        e.hit = 1; e.ticks = n; break;
      end
      if (y >= 700 || x < 0 || x > 1023) begin
        e.ticks = n; break;
      end
    end
    e.x = x & 4095;
    e.y = y & 4095;
    return e;
  endfunction

  task automatic check_end(input string tag, input exp_t e, input logic [11:0] xp,
                           input logic [11:0] yp, input logic h, input logic v,
                           input logic b, input int dur);
    chk({tag, "_x"}, int'(xp), e.x);
    chk({tag, "_y"}, int'(yp), e.y);
    chk({tag, "_hit"}, int'(h), e.hit);
    chk({tag, "_visible"}, int'(v), 0);
    chk({tag, "_busy"}, int'(b), 1);
    chk({tag, "_duration"}, dur, STEP * e.ticks);
  endtask

  // Monitor: pops the scoreboard whenever a DUT reports end of flight.
  int   cyc = 0, sa = 0, sb = 0;
  logic pa_busy = 1'b0, pa_end = 1'b0, pb_busy = 1'b0, pb_end = 1'b0;
  exp_t me;

  always @(negedge clk60MHz) begin
    cyc++;
    if (!rst) begin
      if (a_busy && !pa_busy) sa = cyc;
      if (b_busy && !pb_busy) sb = cyc;
      if (pa_end) chk("a_end_one_cycle", int'(a_end), 0);
      if (pb_end) chk("b_end_one_cycle", int'(b_end), 0);
      if (a_end) begin
        if (qa.size() == 0) chk("a_unexpected_end", 1, 0);
        else begin
          me = qa.pop_front();
          check_end("a_end", me, a_x, a_y, a_hit, a_vis, a_busy, cyc - sa);
        end
      end
      if (b_end) begin
        if (qb.size() == 0) chk("b_unexpected_end", 1, 0);
        else begin
          me = qb.pop_front();
          check_end("b_end", me, b_x, b_y, b_hit, b_vis, b_busy, cyc - sb);
        end
      end
    end
    pa_busy = a_busy; pb_busy = b_busy;
    pa_end  = a_end;  pb_end  = b_end;
  end

  task automatic step();
    @(negedge clk60MHz);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_outputs"}, int'({a_end, a_x, a_y, a_vis, a_hit, a_busy}), 0);
    chk({tag, "_b_outputs"}, int'({b_end, b_x, b_y, b_vis, b_hit, b_busy}), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    throw_flag = 1'b0;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();
  endtask

  task automatic flight(input int pw, input int pl, input int wd, input bit abort);
    exp_t ea, eb;
    int budget;
    power = 4'(pw);
    current_player = pl[0];
`ifdef THROW_TRAJECTORY_WIND_EN
    wind = 4'(wd);
`endif
    ea = model(pw, pl, wd, 900, 880, 560, 40, 60);
    eb = model(pw, pl, wd, 40, 110, 590, 20, 20);
    qa.push_back(ea);
    qb.push_back(eb);
    throw_flag = 1'b1;
    step();
    chk("launch_a_visible", int'(a_vis), 1);
    chk("launch_a_hit_cleared", int'(a_hit), 0);
    chk("launch_b_hit_cleared", int'(b_hit), 0);
    chk("launch_a_xpos", int'(a_x), pl ? 900 : 100);
    chk("launch_b_xpos", int'(b_x), pl ? 40 : 100);
    chk("launch_a_ypos", int'(a_y), 600);
    if (abort) begin
      repeat (4 * STEP + 2) step();
      rst = 1'b1;
      throw_flag = 1'b0;
      step();
      check_zero("abort");
      qa.delete();
      qb.delete();
      rst = 1'b0;
      repeat (3) step();
      chk("abort_a_idle", int'(a_busy), 0);
      chk("abort_b_idle", int'(b_busy), 0);
      return;
    end
    budget = 0;
    while ((qa.size() != 0 || qb.size() != 0) && budget < 1000) begin
      step();
      budget++;
    end
    chk("flight_finished_in_budget", qa.size() + qb.size(), 0);
    if (qa.size() != 0 || qb.size() != 0) begin
      qa.delete();
      qb.delete();
      do_reset();
      return;
    end
    repeat (3) step();
    chk("release_a_busy", int'(a_busy), 1);
    chk("release_b_busy", int'(b_busy), 1);
    chk("release_a_hit_held", int'(a_hit), ea.hit);
    chk("release_b_hit_held", int'(b_hit), eb.hit);
    throw_flag = 1'b0;
    step();
    chk("idle_a_busy", int'(a_busy), 0);
    chk("idle_b_busy", int'(b_busy), 0);
    chk("idle_b_hit_held", int'(b_hit), eb.hit);
    step();
  endtask

  initial begin
    int pw, pl, wd;
    do_reset();
`ifdef THROW_TRAJECTORY_WIND_EN
    flight(0, 0, 3, 1'b0);
`endif
    flight(0, 0, 0, 1'b0);   // ground landing in a, early hit in b
    flight(15, 1, 0, 1'b0);  // left edge exit in b
    flight(0, 0, 0, 1'b1);   // reset mid-flight
    flight(0, 0, 0, 1'b0);   // relaunch after abort
    for (int i = 0; i < 14; i++) begin
      pw = int'($urandom_range(0, 15));
      pl = int'($urandom_range(0, 1));
`ifdef THROW_TRAJECTORY_WIND_EN
      wd = int'($urandom_range(0, 15)) - 8;
`else
      wd = 0;
`endif
      flight(pw, pl, wd, ($urandom_range(0, 5) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
